// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (fetch, data) in front of a single-ported fixed-latency memory.
// Optional fetch-starvation limiter enabled by defining ARB_FAIRNESS_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic              owner_dm_r, owner_dm_s;
  logic              owner_we_r, owner_we_s;
  logic              force_if_s;
  logic              if_gnt_s, if_rvalid_s, dm_gnt_s, dm_rvalid_s;
  logic              mem_en_s, mem_we_s, busy_s;
  logic [DATA_W-1:0] if_rdata_s, dm_rdata_s, mem_wdata_s;
  logic [ADDR_W-1:0] mem_addr_s;

`ifdef ARB_FAIRNESS_EN
  logic [3:0] streak_r, streak_s;

  // Fetch wins a contended cycle once data has taken MAX_STREAK contended grants in a row
  always_comb begin
    force_if_s = if_req && dm_req && (streak_r == 4'(MAX_STREAK));
  end
`else
  logic unused_streak_s;

  // Strict data priority; the streak limit has no effect in this build
  always_comb begin
    force_if_s      = 1'b0;
    unused_streak_s = |4'(MAX_STREAK);
  end
`endif

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    owner_dm_s  = owner_dm_r;
    owner_we_s  = owner_we_r;
    if_gnt_s    = 1'b0;
    dm_gnt_s    = 1'b0;
    if_rvalid_s = 1'b0;
    dm_rvalid_s = 1'b0;
    if_rdata_s  = if_rdata;
    dm_rdata_s  = dm_rdata;
    mem_en_s    = 1'b0;
    mem_we_s    = 1'b0;
    mem_addr_s  = mem_addr;
    mem_wdata_s = mem_wdata;
`ifdef ARB_FAIRNESS_EN
    streak_s    = streak_r;
`endif
    case (state_r)
      IDLE: begin
        if (dm_req && !force_if_s) begin
          dm_gnt_s    = 1'b1;
          mem_en_s    = 1'b1;
          mem_we_s    = dm_we;
          mem_addr_s  = dm_addr;
          mem_wdata_s = dm_wdata;
          owner_dm_s  = 1'b1;
          owner_we_s  = dm_we;
          cnt_s       = 4'(MEM_LAT);
          state_s     = BUSY;
`ifdef ARB_FAIRNESS_EN
          if (!if_req) begin
            streak_s = 4'd0;
          end else if (streak_r < 4'(MAX_STREAK)) begin
            streak_s = streak_r + 4'd1;
          end else begin
            streak_s = streak_r;
          end
`endif
        end else if (if_req) begin
          if_gnt_s    = 1'b1;
          mem_en_s    = 1'b1;
          mem_addr_s  = if_addr;
          owner_dm_s  = 1'b0;
          owner_we_s  = 1'b0;
          cnt_s       = 4'(MEM_LAT);
          state_s     = BUSY;
`ifdef ARB_FAIRNESS_EN
          streak_s    = 4'd0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_s = IDLE;
          if (owner_dm_r) begin
            dm_rvalid_s = 1'b1;
            dm_rdata_s  = owner_we_r ? {DATA_W{1'b0}} : mem_rdata;
          end else begin
            if_rvalid_s = 1'b1;
            if_rdata_s  = mem_rdata;
          end
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
    busy_s = (state_s == BUSY);
  end

  // State, counters and registered outputs; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      owner_dm_r <= 1'b0;
      owner_we_r <= 1'b0;
      if_gnt     <= 1'b0;
      dm_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      dm_rvalid  <= 1'b0;
      if_rdata   <= {DATA_W{1'b0}};
      dm_rdata   <= {DATA_W{1'b0}};
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= {DATA_W{1'b0}};
      busy       <= 1'b0;
`ifdef ARB_FAIRNESS_EN
      streak_r   <= 4'd0;
`endif
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      owner_dm_r <= owner_dm_s;
      owner_we_r <= owner_we_s;
      if_gnt     <= if_gnt_s;
      dm_gnt     <= dm_gnt_s;
      if_rvalid  <= if_rvalid_s;
      dm_rvalid  <= dm_rvalid_s;
      if_rdata   <= if_rdata_s;
      dm_rdata   <= dm_rdata_s;
      mem_en     <= mem_en_s;
      mem_we     <= mem_we_s;
      mem_addr   <= mem_addr_s;
      mem_wdata  <= mem_wdata_s;
      busy       <= busy_s;
`ifdef ARB_FAIRNESS_EN
      streak_r   <= streak_s;
`endif
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single-ported unified memory between two requesters: instruction fetch and the memory stage (loads/stores driven by the control unit's `mem_read`/`mem_write` path).
- Issues one access at a time. The memory has a fixed, parameterized latency.
- The data port has priority; an optional fairness limiter bounds how long fetch can be starved.
- Sits between the fetch/memory pipeline stages and the memory macro. `busy` feeds the pipeline stall logic.

## Interface
Parameters:
- `ADDR_W`, 16, address width
- `DATA_W`, 16, data width (instruction word = data word)
- `MEM_LAT`, 2, memory read latency in cycles, legal range 1..15
- `MAX_STREAK`, 4, consecutive contended data grants before fetch is forced (used only with `ARB_FAIRNESS_EN`), legal range 1..15

Ports:
- `clk`  in  1  single clock, all state on posedge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `if_req`  in  1  fetch request, level; held until `if_gnt`
- `if_addr`  in  ADDR_W  fetch address, stable while `if_req` is high
- `if_gnt`  out  1  one-cycle pulse, fetch request accepted
- `if_rvalid`  out  1  one-cycle pulse, `if_rdata` valid
- `if_rdata`  out  DATA_W  fetched word
- `dm_req`  in  1  data request, level; held until `dm_gnt`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_W  data address
- `dm_wdata`  in  DATA_W  store data
- `dm_gnt`  out  1  one-cycle pulse, data request accepted
- `dm_rvalid`  out  1  one-cycle pulse, load data valid or store complete
- `dm_rdata`  out  DATA_W  load data; 0 on store completion
- `mem_en`  out  1  memory access strobe, one cycle
- `mem_we`  out  1  memory write enable, qualified by `mem_en`
- `mem_addr`  out  ADDR_W  memory address, held for the whole access
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  access in flight (state != IDLE)

## Operation
- FSM states: IDLE, BUSY. All outputs are registered.
- IDLE:
  - Sample `if_req`/`dm_req` at posedge.
  - If neither is high, stay in IDLE.
  - Else select the winner. Drive that port's `gnt`=1, `mem_en`=1, `mem_we`=(winner is data && `dm_we`), and latch `mem_addr`/`mem_wdata`.
  - Load latency counter `cnt`=`MEM_LAT`, record the owner, go to BUSY.
- Arbitration:
  - `dm_req` alone: data.
  - `if_req` alone: fetch.
  - Both high: data, unless the fairness rule below forces fetch.
- BUSY:
  - Requests are ignored; `gnt` and `mem_en` are 0.
  - `cnt` decrements each posedge. On the posedge where `cnt`==1:
    - Assert the owner's `rvalid` for one cycle.
    - Capture `mem_rdata` into the owner's `rdata`; the data port gets 0 for a store.
    - Return to IDLE.
- Requester rule: drop `req` (or present a new request) in the cycle after `gnt`.
  - The arbiter never re-grants the same request, because it is BUSY through that cycle.
- `mem_addr` and `mem_wdata` hold their values from the grant until the next grant.
- `rdata` holds its value until the next `rvalid` for the same port.
- Reset (async, any state):
  - state=IDLE; `cnt`=0; streak=0.
  - All outputs 0, including `rdata` and `mem_addr`.
  - An in-flight access is abandoned; no `rvalid` is produced for it.

## Timing
- Grant latency: `gnt` is high in the cycle after the posedge that samples `req` in IDLE. Minimum 1 cycle.
- Response: `rvalid` is high exactly `MEM_LAT` cycles after the `gnt` cycle.
- `rdata` = `mem_rdata` as sampled at that posedge.
- Throughput: one access per `MEM_LAT`+1 cycles. The `rvalid` cycle is IDLE, so the next `gnt` comes in the following cycle.
- `busy` is high from the `gnt` cycle through the cycle before `rvalid`.
- `if_*` and `dm_*` outputs are never both active in the same cycle.

## Configuration
- Macro `ARB_FAIRNESS_EN`, defined:
  - A streak counter increments on each data grant made while `if_req` was also high.
  - When streak==`MAX_STREAK` and both requests are high, fetch wins.
  - Streak clears on any fetch grant, or on a data grant with `if_req` low.
  - Streak saturates at `MAX_STREAK`.
- Macro undefined:
  - Strict data priority; fetch may starve indefinitely.
  - Streak logic is absent and `MAX_STREAK` is unused.

## Test plan
- Reset, then `if_req`=1, `if_addr`=0x0010, `mem_rdata` model returns 0xA5A5, `MEM_LAT`=2 -> `if_gnt` in cycle 1; `if_rvalid` in cycle 3 with `if_rdata`=0xA5A5; `busy` high in cycles 1-2.
- `if_req`=1 and `dm_req`=1 (`dm_we`=1, `dm_addr`=0x0200, `dm_wdata`=0x1234) in the same cycle -> `dm_gnt` first with `mem_we`=1, `mem_addr`=0x0200, `mem_wdata`=0x1234; `dm_rvalid` with `dm_rdata`=0; `if_gnt` one cycle after `dm_rvalid`.
- `ARB_FAIRNESS_EN` defined, `MAX_STREAK`=4, both requests held high, requests re-raised after each `rvalid` -> grant order D,D,D,D,F,D,D,D,D,F.
- `ARB_FAIRNESS_EN` undefined, same stimulus as the previous scenario -> data grants only; `if_gnt` stays 0 for 20 grants.
- `rst_n` pulled low mid-BUSY (`cnt`=1) -> all outputs 0 immediately; no `rvalid` follows; first request after release is granted normally.
- `MEM_LAT`=1, back-to-back loads -> `gnt`, `rvalid`, `gnt`, `rvalid` in alternating cycles; each `dm_rdata` matches its own address.
